// File: rtl/product_accumulator.sv
// Streaming product accumulator: sums groups of up to LEN unsigned products,
// closing early on in_last, and holds the group result until it is accepted.
module product_accumulator #(
   parameter int PROD_W = 20,
   parameter int ACC_W  = 22,
   parameter int LEN    = 8,
   parameter int CNT_W  = $clog2(LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_product,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_overflow
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               ovf;

   logic               accept;
   logic               close;
   logic               release_res;
   logic [ACC_W:0]     sum;
   logic [CNT_W-1:0]   cnt_inc;
   logic               ovf_nxt;

   // Handshake strobes are derived from the registered state only, so
   // in_ready/out_valid never depend combinationally on any input.
   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      accept      = 1'b0;
      close       = 1'b0;
      release_res = 1'b0;
      sum         = {1'b0, acc} + (ACC_W + 1)'(in_product);
      cnt_inc     = cnt + 1'b1;
      ovf_nxt     = ovf | sum[ACC_W];
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            accept   = in_valid;
            close    = accept & (in_last | (cnt == CNT_W'(LEN - 1)));
            if (close) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid   = 1'b1;
            release_res = out_ready;
            if (release_res) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         out_sum      <= '0;
         out_count    <= '0;
         out_overflow <= 1'b0;
      end else if (accept) begin
         acc <= sum[ACC_W-1:0];
         cnt <= cnt_inc;
         ovf <= ovf_nxt;
         if (close) begin
            out_sum      <= sum[ACC_W-1:0];
            out_count    <= cnt_inc;
            out_overflow <= ovf_nxt;
         end
      end else if (release_res) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator with default parameters.
module tb_product_accumulator;

   localparam int PROD_W = 20;
   localparam int ACC_W  = 22;
   localparam int LEN    = 8;
   localparam int CNT_W  = $clog2(LEN + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [PROD_W-1:0] in_product = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_overflow;

   int checks = 0;
   int errors = 0;
   int accepts = 0;

   product_accumulator #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W),
      .LEN    (LEN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_product   (in_product),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_count    (out_count),
      .out_overflow (out_overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!rst && in_valid && in_ready) accepts++;

   // Drive one product starting at a falling edge; returns at the falling
   // edge after the accepting rising edge with in_valid dropped.
   task automatic send(input logic [PROD_W-1:0] p, input logic last);
      int waited = 0;
      in_valid   = 1'b1;
      in_product = p;
      in_last    = last;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         errors++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      checks++;
      if (out_sum !== 22'd0 || out_count !== 4'd0 || out_overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got sum=%0d count=%0d ovf=%b, required 0/0/0", out_sum, out_count, out_overflow);
      end
   endtask

   task automatic test_full_group();
      out_ready = 1'b1;
      for (int i = 1; i <= 7; i++) send(PROD_W'(i), 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b, required 0", out_valid); end
      send(20'd8, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_hold: got valid=%b ready=%b, required 1/0", out_valid, in_ready);
      end
      checks++;
      if (out_sum !== 22'd36 || out_count !== 4'd8 || out_overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_result: got sum=%0d count=%0d ovf=%b, required 36/8/0", out_sum, out_count, out_overflow);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_bubble: got ready=%b valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_early_close();
      send(20'd100, 1'b0);
      send(20'd200, 1'b0);
      send(20'd300, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 22'd600 || out_count !== 4'd3) begin
         errors++;
         $display("FAIL early_close: got valid=%b sum=%0d count=%0d, required 1/600/3", out_valid, out_sum, out_count);
      end
      @(negedge clk);
      send(20'd5, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 22'd5 || out_count !== 4'd1) begin
         errors++;
         $display("FAIL early_single: got valid=%b sum=%0d count=%0d, required 1/5/1", out_valid, out_sum, out_count);
      end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) send(20'd1046529, 1'b0);
      checks++;
      if (out_sum !== 22'd4177928 || out_count !== 4'd8 || out_overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_result: got sum=%0d count=%0d ovf=%b, required 4177928/8/1", out_sum, out_count, out_overflow);
      end
      @(negedge clk);
      send(20'd1, 1'b0);
      send(20'd1, 1'b1);
      checks++;
      if (out_sum !== 22'd2 || out_count !== 4'd2 || out_overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_cleared: got sum=%0d count=%0d ovf=%b, required 2/2/0", out_sum, out_count, out_overflow);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int base;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(20'd10, 1'b0);
      base       = accepts;
      in_valid   = 1'b1;
      in_product = 20'd99;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 22'd80 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b ready=%b sum=%0d count=%0d, required 1/0/80/8",
                     c, out_valid, in_ready, out_sum, out_count);
         end
         @(negedge clk);
      end
      checks++;
      if (accepts !== base) begin errors++; $display("FAIL bp_absorb: got %0d accepts, required %0d", accepts, base); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got valid=%b ready=%b, required 0/1", out_valid, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (accepts !== base + 1) begin errors++; $display("FAIL bp_next_accept: got %0d accepts, required %0d", accepts, base + 1); end
      send(20'd1, 1'b1);
      checks++;
      if (out_sum !== 22'd100 || out_count !== 4'd2) begin
         errors++;
         $display("FAIL bp_next_group: got sum=%0d count=%0d, required 100/2", out_sum, out_count);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_group();
      send(20'd7, 1'b0);
      send(20'd9, 1'b0);
      send(20'd11, 1'b0);
      rst        = 1'b1;
      in_valid   = 1'b1;
      in_product = 20'd50;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 22'd0 || out_count !== 4'd0 || out_overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got valid=%b ready=%b sum=%0d count=%0d ovf=%b, required 0/1/0/0/0",
                  out_valid, in_ready, out_sum, out_count, out_overflow);
      end
      for (int i = 0; i < 8; i++) send(20'd1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 22'd8 || out_count !== 4'd8) begin
         errors++;
         $display("FAIL rst_mid_regroup: got valid=%b sum=%0d count=%0d, required 1/8/8", out_valid, out_sum, out_count);
      end
      @(negedge clk);
   endtask

   task automatic test_bubbles_reset_hold();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(20'd2, 1'b0);
         if (i < 7) repeat ((i % 2) + 1) @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 22'd16 || out_count !== 4'd8) begin
         errors++;
         $display("FAIL bubbles_result: got valid=%b sum=%0d count=%0d, required 1/16/8", out_valid, out_sum, out_count);
      end
      rst       = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 22'd0 || out_count !== 4'd0) begin
         errors++;
         $display("FAIL hold_reset: got valid=%b ready=%b sum=%0d count=%0d, required 0/1/0/0",
                  out_valid, in_ready, out_sum, out_count);
      end
      send(20'd3, 1'b1);
      checks++;
      if (out_sum !== 22'd3 || out_count !== 4'd1) begin
         errors++;
         $display("FAIL hold_reset_next: got sum=%0d count=%0d, required 3/1", out_sum, out_count);
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_full_group();
      test_early_close();
      test_overflow();
      test_backpressure();
      test_reset_mid_group();
      test_bubbles_reset_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
